csla_stream_stage: RTL and testbench



---
 rtl/csla_pkg.sv | 14 +
 rtl/csla32.sv | 35 +++
 rtl/csla_op_fifo.sv | 48 ++++
 rtl/csla_stream_stage.sv | 81 ++++++++
 tb/tb_csla_stream_stage.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/csla_pkg.sv
// Shared types for the streaming carry-select adder: operand entry layout and adder geometry.
package csla_pkg;

    localparam int ADD_W = 32;
    localparam int BLK_W = 4;

    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
        logic             cin;
        logic             acc;
    } csla_op_t;

endpackage

// File: rtl/csla32.sv
// 32-bit carry-select adder built from 4-bit blocks; purely combinational.
module csla32
    import csla_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    localparam int NBLK = ADD_W / BLK_W;

    logic [NBLK:0] c;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < NBLK; i++) begin : g_blk
            logic [BLK_W:0] r0;
            logic [BLK_W:0] r1;

            // Both carry-in outcomes are precomputed; the incoming block carry only selects.
            assign r0 = {1'b0, a[i*BLK_W +: BLK_W]} + {1'b0, b[i*BLK_W +: BLK_W]};
            assign r1 = {1'b0, a[i*BLK_W +: BLK_W]} + {1'b0, b[i*BLK_W +: BLK_W]} + (BLK_W+1)'(1);

            assign sum[i*BLK_W +: BLK_W] = c[i] ? r1[BLK_W-1:0] : r0[BLK_W-1:0];
            assign c[i+1]                = c[i] ? r1[BLK_W]     : r0[BLK_W];
        end
    endgenerate

    assign cout = c[NBLK];

endmodule

// File: rtl/csla_op_fifo.sv
// Operand FIFO, DEPTH entries, head visible combinationally; pushes ignored when full, pops when empty.
module csla_op_fifo
    import csla_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  csla_op_t       push_dat,
    input  logic           pop,
    output csla_op_t       head,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] level
);

    csla_op_t       mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer bit keeps full and empty distinct at every wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_dat;
    end

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (PTR_W+1)'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/csla_stream_stage.sv
// Queued add/accumulate unit: FIFO head feeds csla32, result registered one edge after load.
// Output holds while out_valid && !out_ready; in_ready is !full with no same-cycle bypass.
module csla_stream_stage
    import csla_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ADD_W-1:0] in_a,
    input  logic [ADD_W-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ADD_W-1:0] out_sum,
    output logic             out_cout,
    output logic [PTR_W:0]   fifo_level
);

    csla_op_t         push_dat;
    csla_op_t         head;
    logic             full;
    logic             empty;
    logic             load;
    logic [ADD_W-1:0] accum;
    logic [ADD_W-1:0] acc_eff;
    logic [ADD_W-1:0] a_eff;
    logic [ADD_W-1:0] sum;
    logic             cout;

    assign push_dat = {in_a, in_b, in_cin, in_acc};
    assign in_ready = !full;
    assign load     = !empty && (!out_valid || out_ready);

    csla_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .push_dat (push_dat),
        .pop      (load),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

    // A clear arriving with the load is seen by that operation, not the next one.
    assign acc_eff = acc_clr ? '0 : accum;
    assign a_eff   = head.acc ? acc_eff : head.a;

    csla32 u_add (
        .a    (a_eff),
        .b    (head.b),
        .cin  (head.cin),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            accum     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_cout  <= cout;
            accum     <= sum;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (acc_clr)                accum     <= '0;
        end
    end

endmodule

// File: tb/tb_csla_stream_stage.sv
// Directed and randomised checks of the streaming add/accumulate stage against hand-computed results.
module tb_csla_stream_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_acc;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic [2:0]  fifo_level;

    int          total = 0;
    int          bad   = 0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    bit          prod_done;

    always #5 clk = ~clk;

    csla_stream_stage #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .in_acc     (in_acc),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .fifo_level (fifo_level)
    );

    // Results are taken at the falling edge, where valid and ready are settled for the coming rise.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back({out_cout, out_sum});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic acc);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_acc   = acc;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input logic [31:0] s, input logic c);
        exp_q.push_back({c, s});
    endtask

    task automatic drain_check(input string tag);
        int n;
        int cyc;
        n   = exp_q.size();
        cyc = 0;
        while (got_q.size() < n && cyc < 100) begin
            tick;
            cyc++;
        end
        chk($sformatf("%s_count", tag), got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] fa [6];
        logic [31:0] fb [6];
        logic        fc [6];
        fa = '{32'd10, 32'd20, 32'hFFFF_FFF0, 32'd40, 32'd50, 32'd60};
        fb = '{32'd1,  32'd2,  32'h20,        32'd4,  32'd5,  32'd6};
        fc = '{1'b0,   1'b1,   1'b0,          1'b1,   1'b0,   1'b1};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0; prod_done = 1'b0;
        #2;
        chk("rst_vld",   out_valid, 0);
        chk("rst_sum",   out_sum, 0);
        chk("rst_cout",  out_cout, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_rdy",   in_ready, 1);
        tick;
        rst = 1'b0;

        // single add, latency and carry-out
        out_ready = 1'b1;
        push_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        chk("lat_early", out_valid, 0);
        tick;
        chk("lat_vld",  out_valid, 1);
        chk("lat_sum",  out_sum, 0);
        chk("lat_cout", out_cout, 1);
        expect_res(32'h0, 1'b1);
        push_op(32'h0, 32'h0, 1'b0, 1'b1);
        expect_res(32'h0, 1'b0);
        drain_check("single");

        // accumulate chain seeded by a plain add
        push_op(32'd5, 32'd0, 1'b0, 1'b0);
        push_op(32'd0, 32'd3, 1'b0, 1'b1);
        push_op(32'd0, 32'd4, 1'b0, 1'b1);
        push_op(32'd0, 32'hFFFF_FFF8, 1'b0, 1'b1);
        expect_res(32'd5, 1'b0);
        expect_res(32'd8, 1'b0);
        expect_res(32'd12, 1'b0);
        expect_res(32'd4, 1'b1);
        drain_check("chain");

        // clear while idle, then clear colliding with an accumulate load
        acc_clr = 1'b1;
        tick;
        acc_clr = 1'b0;
        push_op(32'd0, 32'd5, 1'b0, 1'b1);
        expect_res(32'd5, 1'b0);
        push_op(32'd100, 32'd0, 1'b0, 1'b0);
        expect_res(32'd100, 1'b0);
        in_a = 32'd0; in_b = 32'd7; in_cin = 1'b0; in_acc = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        acc_clr  = 1'b1;
        tick;
        acc_clr  = 1'b0;
        expect_res(32'd7, 1'b0);
        push_op(32'd0, 32'd0, 1'b0, 1'b1);
        expect_res(32'd7, 1'b0);
        drain_check("accclr");

        // fill under back-pressure, sixth push refused
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_a = fa[i]; in_b = fb[i]; in_cin = fc[i]; in_acc = 1'b0; in_valid = 1'b1;
            chk($sformatf("full_rdy_%0d", i), in_ready, (i < 5) ? 1 : 0);
            tick;
        end
        in_valid = 1'b0;
        chk("full_level", fifo_level, 4);
        chk("full_vld",   out_valid, 1);
        chk("full_sum",   out_sum, 11);
        tick; tick; tick;
        chk("hold_vld", out_valid, 1);
        chk("hold_sum", out_sum, 11);
        out_ready = 1'b1;
        chk("pop_cycle_rdy", in_ready, 0);
        tick;
        chk("after_pop_rdy",   in_ready, 1);
        chk("after_pop_level", fifo_level, 3);
        expect_res(32'd11, 1'b0);
        expect_res(32'd23, 1'b0);
        expect_res(32'h10, 1'b1);
        expect_res(32'd45, 1'b0);
        expect_res(32'd55, 1'b0);
        drain_check("drain");
        tick; tick; tick;
        chk("no_sixth", got_q.size(), 0);
        chk("drained_level", fifo_level, 0);

        // reset in the middle of a stream
        out_ready = 1'b0;
        push_op(32'd1, 32'd2, 1'b0, 1'b0);
        push_op(32'd3, 32'd4, 1'b0, 1'b0);
        push_op(32'd5, 32'd6, 1'b0, 1'b0);
        chk("pre_rst_vld", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld",   out_valid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_rdy",   in_ready, 1);
        chk("mid_rst_sum",   out_sum, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        push_op(32'd1, 32'd1, 1'b0, 1'b0);
        expect_res(32'd2, 1'b0);
        drain_check("post_rst");

        // random stream across several pointer wraps with random back-pressure
        fork
            begin : prod
                int sent;
                int guard;
                logic [31:0] ra;
                logic [31:0] rb;
                logic        rc;
                sent  = 0;
                guard = 0;
                while (sent < 13 && guard < 2000) begin
                    ra = $urandom;
                    rb = $urandom;
                    rc = 1'($urandom_range(0, 1));
                    in_a = ra; in_b = rb; in_cin = rc; in_acc = 1'b0; in_valid = 1'b1;
                    while (!in_ready && guard < 2000) begin
                        tick;
                        guard++;
                    end
                    tick;
                    guard++;
                    exp_q.push_back({1'b0, ra} + {1'b0, rb} + 33'(rc));
                    in_valid = 1'b0;
                    sent++;
                    if ($urandom_range(0, 2) == 0) tick;
                end
                prod_done = 1'b1;
            end
            begin : tog
                while (!prod_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick;
                end
            end
        join
        out_ready = 1'b1;
        drain_check("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
